// File: rtl/div_pkg.sv
// Shared types for the iterative integer divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Restoring divider on operand magnitudes, one quotient bit per cycle, then sign fix-up.
// Latency DATA_WIDTH+1 cycles (1 for a zero divisor); holds the result until out_ready.
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  div_op_t               op,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] opr_result
);

  localparam int CW = $clog2(DATA_WIDTH);

  div_state_t            r_state;
  div_state_t            w_state_nxt;
  div_op_t               r_op;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_div;
  logic [CW-1:0]         r_cnt;
  logic                  r_neg_q;
  logic                  r_neg_r;

  logic                  w_accept;
  logic                  w_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic [DATA_WIDTH:0]   w_shift;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_diff;
  logic [DATA_WIDTH-1:0] w_q_fix;
  logic [DATA_WIDTH-1:0] w_r_fix;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_signed = (op == DIV) || (op == REM);
  assign w_a_neg  = w_signed && opr_a[DATA_WIDTH-1];
  assign w_b_neg  = w_signed && opr_b[DATA_WIDTH-1];
  // Negating the most-negative value yields 2^(W-1), which is its correct unsigned magnitude.
  assign w_a_mag  = w_a_neg ? (~opr_a + 1'b1) : opr_a;
  assign w_b_mag  = w_b_neg ? (~opr_b + 1'b1) : opr_b;

  // The partial remainder stays below the divisor, so the shifted value needs one extra bit
  // and a successful trial difference always fits back into DATA_WIDTH bits.
  assign w_shift  = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_ge     = w_shift >= {1'b0, r_div};
  assign w_diff   = w_shift[DATA_WIDTH-1:0] - r_div;

  assign w_q_fix  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix  = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    opr_result  = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (opr_b == '0) ? DONE : CALC;
      end
      CALC: begin
        if (r_cnt == '0) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        opr_result = ((r_op == REM) || (r_op == REMU)) ? w_r_fix : w_q_fix;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= DIV;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_op  <= op;
      r_div <= w_b_mag;
      r_cnt <= CW'(DATA_WIDTH - 1);
      if (opr_b == '0) begin
        // Divide by zero: all-ones quotient, dividend as remainder, no fix-up.
        r_quo   <= '1;
        r_rem   <= opr_a;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_quo   <= w_a_mag;
        r_rem   <= '0;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_ge ? w_diff : w_shift[DATA_WIDTH-1:0];
      r_quo <= {r_quo[DATA_WIDTH-2:0], w_ge};
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
